// File: rtl/meas_pkg.sv
// Shared state type and constants for the measurement result converter.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_DIV_F = 3'd2,
        ST_DIV_D = 3'd3,
        ST_DONE  = 3'd4
    } meas_state_t;

    localparam int unsigned PERMILLE_SCALE = 1000;
    localparam int unsigned DUTY_MAX       = 1000;
    localparam int unsigned DUTY_W         = 10;

endpackage

// File: rtl/measurement_result_calc_if.sv
// Upstream raw-result handshake and M1 register-read signals of the converter.
interface measurement_result_calc_if;
    import meas_pkg::*;

    logic              meas_ready;
    logic [31:0]       period_count;
    logic [31:0]       high_time_count;
    logic              meas_ack;
    logic              result_valid;
    logic [31:0]       freq_hz;
    logic [DUTY_W-1:0] duty_permille;
    logic              result_err;
    logic              rd_ack;

    modport slave (
        input  meas_ready, period_count, high_time_count, rd_ack,
        output meas_ack, result_valid, freq_hz, duty_permille, result_err
    );

    modport master (
        output meas_ready, period_count, high_time_count, rd_ack,
        input  meas_ack, result_valid, freq_hz, duty_permille, result_err
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, done pulses W cycles after an accepted start.
module seq_divider #(
    parameter int unsigned W = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [W:0]       w_shift;
    logic [W-1:0]     w_diff;
    logic             w_ge;

    // r_quo doubles as the dividend shift register; quotient bits enter at the bottom.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_ge    = w_shift >= {1'b0, r_div};
    assign w_diff  = w_shift[W-1:0] - r_div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_rem <= w_ge ? w_diff : w_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], w_ge};
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (start) begin
                r_rem  <= '0;
                r_quo  <= dividend;
                r_div  <= divisor;
                r_cnt  <= CNT_W'(W);
                r_busy <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/measurement_result_calc.sv
// Captures raw period/high counts and converts them to Hz and permille with one shared divider.
module measurement_result_calc
    import meas_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DIV_W       = 48
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            busy,
    measurement_result_calc_if.slave        bus
);
    meas_state_t       r_state;
    meas_state_t       w_next;

    logic [31:0]       r_period;
    logic [31:0]       r_high;
    logic [31:0]       r_freq_stage;
    logic [31:0]       r_freq;
    logic [DUTY_W-1:0] r_duty;
    logic              r_err;
    logic              r_valid;

    logic              w_ack;
    logic              w_high_gt;
    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [DIV_W-1:0]  w_div_dividend;
    logic [DIV_W-1:0]  w_div_divisor;
    logic [DIV_W-1:0]  w_duty_dividend;
    logic [DIV_W-1:0]  w_div_quo;
    logic [DIV_W-1:0]  w_div_rem_unused;
    logic              w_quo_hi_unused;

    assign w_high_gt       = r_high > r_period;
    assign w_div_divisor   = DIV_W'(r_period);
    assign w_duty_dividend = DIV_W'(r_high) * DIV_W'(PERMILLE_SCALE);
    assign w_quo_hi_unused = ^w_div_quo[DIV_W-1:32];

    seq_divider #(
        .W(DIV_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (w_div_dividend),
        .divisor   (w_div_divisor),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Capture waits for the divider to go idle, so an aborted division can never leak a stale done.
    always_comb begin
        w_next         = r_state;
        w_ack          = 1'b0;
        w_div_start    = 1'b0;
        w_div_dividend = DIV_W'(CLK_FREQ_HZ);
        case (r_state)
            ST_IDLE: begin
                if (enable && bus.meas_ready && !w_div_busy) w_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_ack = 1'b1;
                if (!enable) begin
                    w_next = ST_IDLE;
                end else if (r_period == '0) begin
                    w_next = ST_DONE;
                end else begin
                    w_next      = ST_DIV_F;
                    w_div_start = 1'b1;
                end
            end
            ST_DIV_F: begin
                if (!enable) begin
                    w_next = ST_IDLE;
                end else if (w_div_done) begin
                    w_next = ST_DIV_D;
                    if (!w_high_gt) begin
                        w_div_start    = 1'b1;
                        w_div_dividend = w_duty_dividend;
                    end
                end
            end
            ST_DIV_D: begin
                if (!enable)                      w_next = ST_IDLE;
                else if (w_high_gt || w_div_done) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rd_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period     <= '0;
            r_high       <= '0;
            r_freq_stage <= '0;
            r_freq       <= '0;
            r_duty       <= '0;
            r_err        <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= (w_next == ST_DONE);
            if (r_state == ST_IDLE && w_next == ST_LATCH) begin
                r_period <= bus.period_count;
                r_high   <= bus.high_time_count;
            end
            if (r_state == ST_DIV_F && w_next == ST_DIV_D) r_freq_stage <= w_div_quo[31:0];
            // Visible results change only on entry to DONE.
            if (r_state != ST_DONE && w_next == ST_DONE) begin
                if (r_state == ST_LATCH) begin
                    r_freq <= '0;
                    r_duty <= '0;
                    r_err  <= 1'b1;
                end else if (w_high_gt) begin
                    r_freq <= r_freq_stage;
                    r_duty <= DUTY_W'(DUTY_MAX);
                    r_err  <= 1'b1;
                end else begin
                    r_freq <= r_freq_stage;
                    r_duty <= w_div_quo[DUTY_W-1:0];
                    r_err  <= 1'b0;
                end
            end
        end
    end

    assign busy              = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.meas_ack      = w_ack;
    assign bus.result_valid  = r_valid;
    assign bus.freq_hz       = r_freq;
    assign bus.duty_permille = r_duty;
    assign bus.result_err    = r_err;

endmodule

// File: tb/tb_measurement_result_calc.sv
// Randomized and directed checks of measurement_result_calc against an arithmetic reference model.
module tb_measurement_result_calc;
    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned DIV_W  = 48;
    localparam int unsigned BUDGET = 4 * DIV_W + 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        busy;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    measurement_result_calc_if u_if();

    measurement_result_calc #(
        .CLK_FREQ_HZ(CLK_HZ),
        .DIV_W      (DIV_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .busy  (busy),
        .bus   (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] p, input logic [31:0] h,
                                  output logic [63:0] f, output logic [63:0] d,
                                  output logic [63:0] e);
        longint unsigned lp, lh;
        lp = 64'(p);
        lh = 64'(h);
        if (lp == 0) begin
            f = 0; d = 0; e = 1;
        end else begin
            f = (64'(CLK_HZ) / lp) & 64'hFFFF_FFFF;
            if (lh > lp) begin
                d = 1000; e = 1;
            end else begin
                d = (lh * 1000) / lp; e = 0;
            end
        end
    endfunction

    // Returns the number of edges from the capture edge (exclusive) to the edge raising result_valid.
    task automatic start_and_wait(input logic [31:0] p, input logic [31:0] h, output int unsigned lat);
        int unsigned t_ack;
        int unsigned extra;
        bit          seen;
        u_if.period_count    = p;
        u_if.high_time_count = h;
        u_if.meas_ready      = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < int'(BUDGET) && !seen; i++) begin
            @(negedge clk);
            if (u_if.meas_ack) seen = 1'b1;
        end
        check_eq("ack_seen", 64'(seen), 64'd1);
        t_ack = cyc;
        u_if.meas_ready = 1'b0;
        seen  = 1'b0;
        extra = 0;
        for (int i = 0; i < int'(BUDGET) && !seen; i++) begin
            @(negedge clk);
            if (u_if.meas_ack)     extra++;
            if (u_if.result_valid) seen = 1'b1;
        end
        check_eq("valid_seen", 64'(seen), 64'd1);
        check_eq("ack_once", 64'(extra), 64'd0);
        lat = cyc - t_ack;
    endtask

    task automatic check_results(input string tag, input logic [31:0] p, input logic [31:0] h);
        logic [63:0] f, d, e;
        model(p, h, f, d, e);
        check_eq({tag, "_freq"}, 64'(u_if.freq_hz), f);
        check_eq({tag, "_duty"}, 64'(u_if.duty_permille), d);
        check_eq({tag, "_err"},  64'(u_if.result_err), e);
    endtask

    task automatic read_out();
        u_if.rd_ack = 1'b1;
        @(negedge clk);
        check_eq("valid_drop", 64'(u_if.result_valid), 64'd0);
        check_eq("idle_after_read", 64'(busy), 64'd0);
        u_if.rd_ack = 1'b0;
    endtask

    // Valid rises 2*DIV_W+4 edges after capture counting both edges, i.e. 2*DIV_W+3 edges later.
    task automatic run_txn(input string tag, input logic [31:0] p, input logic [31:0] h);
        int unsigned lat;
        start_and_wait(p, h, lat);
        if (p == 0)     check_eq({tag, "_lat_zero"}, 64'(lat), 64'd1);
        else if (h <= p) check_eq({tag, "_lat"}, 64'(lat), 64'(2 * DIV_W + 3));
        check_results(tag, p, h);
        read_out();
    endtask

    initial begin
        logic [31:0] p, h;
        logic [63:0] ef, ed, ee;
        int unsigned lat;
        int unsigned cnt;

        reset                = 1'b1;
        enable               = 1'b0;
        u_if.meas_ready      = 1'b0;
        u_if.period_count    = '0;
        u_if.high_time_count = '0;
        u_if.rd_ack          = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 64'(u_if.result_valid), 64'd0);
        check_eq("rst_freq",  64'(u_if.freq_hz), 64'd0);
        check_eq("rst_duty",  64'(u_if.duty_permille), 64'd0);
        check_eq("rst_err",   64'(u_if.result_err), 64'd0);
        check_eq("rst_ack",   64'(u_if.meas_ack), 64'd0);
        check_eq("rst_busy",  64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // meas_ready is ignored while disabled
        u_if.period_count    = 32'd10;
        u_if.high_time_count = 32'd5;
        u_if.meas_ready      = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (u_if.meas_ack) cnt++;
        end
        check_eq("disabled_no_ack", 64'(cnt), 64'd0);
        u_if.meas_ready = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        run_txn("nominal", 32'd50000, 32'd12500);
        run_txn("floor3",  32'd3, 32'd1);
        run_txn("p1h1",    32'd1, 32'd1);
        run_txn("pzero",   32'd0, 32'd7);
        run_txn("clamp",   32'd100, 32'd150);

        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 3))
                0:       p = $urandom_range(1, 64);
                1:       p = $urandom;
                2:       p = $urandom_range(1000, 2_000_000);
                default: p = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(2, 9));
            endcase
            if ($urandom_range(0, 4) == 0) h = p + 32'($urandom_range(1, 100));
            else                           h = $urandom_range(0, p);
            run_txn("rand", p, h);
        end

        // Backpressure: a pending second capture waits for the read
        start_and_wait(32'd1000, 32'd300, lat);
        check_results("bp1", 32'd1000, 32'd300);
        u_if.period_count    = 32'd7;
        u_if.high_time_count = 32'd2;
        u_if.meas_ready      = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (u_if.meas_ack) cnt++;
        end
        check_eq("bp_no_ack", 64'(cnt), 64'd0);
        check_eq("bp_valid_held", 64'(u_if.result_valid), 64'd1);
        check_results("bp_hold", 32'd1000, 32'd300);
        u_if.rd_ack = 1'b1;
        @(negedge clk);
        u_if.rd_ack = 1'b0;
        check_eq("bp_valid_drop", 64'(u_if.result_valid), 64'd0);
        check_eq("bp_gap_no_ack", 64'(u_if.meas_ack), 64'd0);
        @(negedge clk);
        check_eq("bp_second_ack", 64'(u_if.meas_ack), 64'd1);
        u_if.meas_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < int'(BUDGET) && cnt == 0; i++) begin
            @(negedge clk);
            if (u_if.result_valid) cnt = 1;
        end
        check_eq("bp2_valid_seen", 64'(cnt), 64'd1);
        check_results("bp2", 32'd7, 32'd2);
        read_out();

        // Abort 20 cycles into the frequency division
        u_if.period_count    = 32'd50000;
        u_if.high_time_count = 32'd12500;
        u_if.meas_ready      = 1'b1;
        cnt = 0;
        for (int i = 0; i < int'(BUDGET) && cnt == 0; i++) begin
            @(negedge clk);
            if (u_if.meas_ack) cnt = 1;
        end
        check_eq("abort_ack_seen", 64'(cnt), 64'd1);
        u_if.meas_ready = 1'b0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq("abort_busy_div", 64'(busy), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", 64'(busy), 64'd0);
        cnt = 0;
        repeat (2 * DIV_W + 10) begin
            @(negedge clk);
            if (u_if.result_valid) cnt++;
        end
        check_eq("abort_no_valid", 64'(cnt), 64'd0);
        model(32'd7, 32'd2, ef, ed, ee);
        check_eq("abort_freq_kept", 64'(u_if.freq_hz), ef);
        enable = 1'b1;
        @(negedge clk);

        // Asynchronous reset during the duty division
        u_if.meas_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < int'(BUDGET) && cnt == 0; i++) begin
            @(negedge clk);
            if (u_if.meas_ack) cnt = 1;
        end
        check_eq("rst2_ack_seen", 64'(cnt), 64'd1);
        u_if.meas_ready = 1'b0;
        repeat (DIV_W + 10) @(negedge clk);
        check_eq("rst2_busy_div", 64'(busy), 64'd1);
        check_eq("rst2_freq_before", 64'(u_if.freq_hz), ef);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 64'(u_if.result_valid), 64'd0);
        check_eq("arst_freq",  64'(u_if.freq_hz), 64'd0);
        check_eq("arst_duty",  64'(u_if.duty_permille), 64'd0);
        check_eq("arst_err",   64'(u_if.result_err), 64'd0);
        check_eq("arst_busy",  64'(busy), 64'd0);
        check_eq("arst_ack",   64'(u_if.meas_ack), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn("post_rst", 32'd50000, 32'd12500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
